// File: rtl/alu_stim_gen.sv
// Operand-vector generator for the pipelined ALU: random, corner-weighted or sweep vectors
// issued over a valid/ready handshake, a programmed number per run.
module alu_stim_gen #(
    parameter int unsigned OPERAND_WIDTH = 8,
    parameter int unsigned OPCODE_WIDTH  = 5,
    parameter int unsigned LFSR_WIDTH    = 16,
    parameter int unsigned RUN_WIDTH     = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(16'hACE1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [OPCODE_WIDTH-1:0]  op_sel,
    input  logic [RUN_WIDTH-1:0]     num_runs,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [OPCODE_WIDTH-1:0]  operation,
    output logic [OPERAND_WIDTH-1:0] operand_a,
    output logic [OPERAND_WIDTH-1:0] operand_b,
    output logic                     carry_in,
    output logic                     busy,
    output logic                     done,
    output logic [RUN_WIDTH-1:0]     issued_count
);

    localparam logic [LFSR_WIDTH-1:0] LfsrMask = LFSR_WIDTH'(16'hB400);
    localparam logic [LFSR_WIDTH-1:0] SeedB    = SEED ^ LFSR_WIDTH'(16'h5A5A);

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [OPCODE_WIDTH-1:0]  operation_q, operation_d;
    logic [RUN_WIDTH-1:0]     num_runs_q, num_runs_d;
    logic [RUN_WIDTH-1:0]     issued_q, issued_d, issued_inc;
    logic [OPERAND_WIDTH-1:0] operand_a_q, operand_a_d, operand_b_q, operand_b_d;
    logic [OPERAND_WIDTH-1:0] sweep_a, sweep_b;
    logic                     carry_q, carry_d;
    logic [LFSR_WIDTH-1:0]    lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic                     gen;
    logic [1:0]               gen_mode;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] l);
        return (l >> 1) ^ (l[0] ? LfsrMask : '0);
    endfunction

    // Mode 1 uses the two top LFSR bits to pick zero / one / all-ones / random.
    function automatic logic [OPERAND_WIDTH-1:0] pick_operand(input logic [1:0] m,
                                                              input logic [LFSR_WIDTH-1:0] l);
        logic [OPERAND_WIDTH-1:0] r;
        r = l[OPERAND_WIDTH-1:0];
        if (m == 2'd1) begin
            case (l[LFSR_WIDTH-1 -: 2])
                2'b00:   r = '0;
                2'b01:   r = OPERAND_WIDTH'(1);
                2'b10:   r = '1;
                default: r = l[OPERAND_WIDTH-1:0];
            endcase
        end
        return r;
    endfunction

    assign op_valid = (state_q == StDrive);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        operation_d = operation_q;
        num_runs_d  = num_runs_q;
        issued_d    = issued_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        carry_d     = carry_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        gen         = 1'b0;
        gen_mode    = mode_q;
        issued_inc  = issued_q + RUN_WIDTH'(1);
        sweep_a     = operand_a_q + OPERAND_WIDTH'(1);
        sweep_b     = (operand_a_q == '1) ? operand_b_q + OPERAND_WIDTH'(1) : operand_b_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    mode_d      = mode;
                    operation_d = op_sel;
                    num_runs_d  = num_runs;
                    issued_d    = '0;
                    if (num_runs == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StDrive;
                        gen      = 1'b1;
                        gen_mode = mode;
                        sweep_a  = '0;
                        sweep_b  = '0;
                    end
                end
            end
            StDrive: begin
                if (op_valid && op_ready) begin
                    issued_d = issued_inc;
                    if (issued_inc == num_runs_q) begin
                        state_d = StDone;
                    end else begin
                        gen = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // LFSRs advance once per generated vector, in every mode including sweep.
        if (gen) begin
            lfsr_a_d = lfsr_step(lfsr_a_q);
            lfsr_b_d = lfsr_step(lfsr_b_q);
            if (gen_mode == 2'd2) begin
                operand_a_d = sweep_a;
                operand_b_d = sweep_b;
                carry_d     = 1'b0;
            end else begin
                operand_a_d = pick_operand(gen_mode, lfsr_a_q);
                operand_b_d = pick_operand(gen_mode, lfsr_b_q);
                carry_d     = lfsr_a_q[LFSR_WIDTH-3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= 2'd0;
            operation_q <= '0;
            num_runs_q  <= '0;
            issued_q    <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            carry_q     <= 1'b0;
            lfsr_a_q    <= SEED;
            lfsr_b_q    <= SeedB;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            operation_q <= operation_d;
            num_runs_q  <= num_runs_d;
            issued_q    <= issued_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            carry_q     <= carry_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
        end
    end

    assign operation    = operation_q;
    assign operand_a    = operand_a_q;
    assign operand_b    = operand_b_q;
    assign carry_in     = carry_q;
    assign busy         = (state_q == StDrive);
    assign done         = (state_q == StDone);
    assign issued_count = issued_q;

endmodule

// File: tb/tb_alu_stim_gen.sv
// Scoreboard bench: expected vectors are queued at issue, monitors pop on each transfer.
module tb_alu_stim_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, start2 = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [4:0]  op_sel = 5'd0;
    logic [15:0] num_runs = 16'd0;
    logic        op_ready = 1'b1;

    logic        v1, c1, busy1, done1;
    logic [4:0]  operation1;
    logic [7:0]  a1, b1;
    logic [15:0] cnt1;

    logic        v2, c2, busy2, done2;
    logic [4:0]  operation2;
    logic [1:0]  a2, b2;
    logic [15:0] cnt2;

    alu_stim_gen dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .op_sel(op_sel),
        .num_runs(num_runs), .op_valid(v1), .op_ready(op_ready), .operation(operation1),
        .operand_a(a1), .operand_b(b1), .carry_in(c1), .busy(busy1), .done(done1),
        .issued_count(cnt1)
    );

    alu_stim_gen #(.OPERAND_WIDTH(2)) dut_sweep (
        .clk(clk), .reset(reset), .start(start2), .mode(mode), .op_sel(op_sel),
        .num_runs(num_runs), .op_valid(v2), .op_ready(op_ready), .operation(operation2),
        .operand_a(a2), .operand_b(b2), .carry_in(c2), .busy(busy2), .done(done2),
        .issued_count(cnt2)
    );

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
    } vec_t;

    vec_t q1[$];
    vec_t q2[$];
    int checks = 0;
    int errors = 0;
    int xfers1 = 0, valid_cyc1 = 0;
    int n_zero = 0, n_one = 0, n_ff = 0;
    logic count_en = 1'b0;
    logic bp_en = 1'b0;

    // First vectors after reset, worked out by hand from the two seeds.
    logic [7:0] hand_a [5] = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E};
    logic [7:0] hand_b [5] = '{8'hBB, 8'h5D, 8'hAE, 8'hD7, 8'hEB};
    logic       hand_c [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] sw_a [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] sw_b [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};

    logic [15:0] ma = 16'hACE1;
    logic [15:0] mb = 16'hACE1 ^ 16'h5A5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [7:0] mpick(input logic [1:0] m, input logic [15:0] l);
        if (m != 2'd1) return l[7:0];
        case (l[15:14])
            2'b00:   return 8'h00;
            2'b01:   return 8'h01;
            2'b10:   return 8'hFF;
            default: return l[7:0];
        endcase
    endfunction

    task automatic push_hand(input int first, input int n, input logic [4:0] op);
        for (int k = first; k < first + n; k++) begin
            q1.push_back({op, hand_a[k], hand_b[k], hand_c[k]});
            ma = step(ma);
            mb = step(mb);
        end
    endtask

    task automatic gen_push(input logic [1:0] m, input logic [4:0] op, input int n);
        for (int k = 0; k < n; k++) begin
            q1.push_back({op, mpick(m, ma), mpick(m, mb), ma[13]});
            ma = step(ma);
            mb = step(mb);
        end
    endtask

    // Issue one run and wait for done; waited = edges after the start edge.
    task automatic do_run(input bit second, input logic [1:0] m, input logic [4:0] op,
                          input logic [15:0] n, input bit glitch, output int waited);
        @(posedge clk); #1;
        mode = m;
        op_sel = op;
        num_runs = n;
        if (second) start2 = 1'b1;
        else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start2 = 1'b0;
        mode = ~m;
        op_sel = ~op;
        num_runs = 16'hFFFF;
        waited = 0;
        while (!(second ? done2 : done1) && waited < 20000) begin
            if (glitch && waited == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            waited++;
        end
        check("run_completes", waited < 20000, 1);
    endtask

    initial begin : ready_driver
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                op_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                op_ready = 1'b1;
                ph = 0;
            end
        end
    end

    initial begin : monitor1
        vec_t cur, held, exp;
        logic stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else if (v1) begin
                valid_cyc1++;
                cur = {operation1, a1, b1, c1};
                if (stalled) check("stall_hold", cur, held);
                if (op_ready) begin
                    xfers1++;
                    stalled = 1'b0;
                    if (q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vec: got %h expected none", cur);
                    end else begin
                        exp = q1.pop_front();
                        check("vec", cur, exp);
                    end
                    if (count_en) begin
                        if (a1 == 8'h00) n_zero++;
                        if (a1 == 8'h01) n_one++;
                        if (a1 == 8'hFF) n_ff++;
                    end
                end else begin
                    held = cur;
                    stalled = 1'b1;
                end
            end else if (stalled) begin
                check("valid_held", v1, 1);
                stalled = 1'b0;
            end
        end
    end

    initial begin : monitor2
        vec_t cur, exp;
        forever begin
            @(negedge clk);
            if (!reset && v2 && op_ready) begin
                cur = {operation2, 6'b0, a2, 6'b0, b2, c2};
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sweep: got %h expected none", cur);
                end else begin
                    exp = q2.pop_front();
                    check("sweep_vec", cur, exp);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int w, base, cyc;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", v1, 0);
        check("rst_done", done1, 0);
        check("rst_busy", busy1, 0);
        check("rst_count", cnt1, 0);
        check("rst_vector", {operation1, a1, b1, c1}, 0);
        reset = 1'b0;

        do_run(1'b0, 2'd0, 5'h03, 16'd0, 1'b0, w);
        check("zero_latency", w, 0);
        check("zero_done", done1, 1);
        check("zero_count", cnt1, 0);
        check("zero_no_valid", valid_cyc1, 0);

        push_hand(0, 1, 5'h11);
        do_run(1'b0, 2'd0, 5'h11, 16'd1, 1'b0, w);
        check("one_count", cnt1, 1);
        check("one_latency", w, 1);

        base = valid_cyc1;
        push_hand(1, 4, 5'h07);
        do_run(1'b0, 2'd0, 5'h07, 16'd4, 1'b0, w);
        check("b2b_latency", w, 4);
        check("b2b_valid_cycles", valid_cyc1 - base, 4);
        check("b2b_count", cnt1, 4);
        check("b2b_end_state", {v1, busy1, done1}, 3'b001);

        base = xfers1;
        bp_en = 1'b1;
        gen_push(2'd3, 5'h1C, 4);
        do_run(1'b0, 2'd3, 5'h1C, 16'd4, 1'b1, w);
        bp_en = 1'b0;
        check("bp_transfers", xfers1 - base, 4);
        check("bp_count", cnt1, 4);
        check("bp_drained", q1.size(), 0);

        for (int k = 0; k < 6; k++) q2.push_back({5'h0A, 6'b0, sw_a[k], 6'b0, sw_b[k], 1'b0});
        do_run(1'b1, 2'd2, 5'h0A, 16'd6, 1'b0, w);
        check("sweep_latency", w, 6);
        check("sweep_count", cnt2, 6);
        check("sweep_drained", q2.size(), 0);

        count_en = 1'b1;
        gen_push(2'd1, 5'h02, 4096);
        do_run(1'b0, 2'd1, 5'h02, 16'd4096, 1'b0, w);
        count_en = 1'b0;
        check("weighted_count", cnt1, 4096);
        check("weighted_zero_share", (n_zero >= 902 && n_zero <= 1146), 1);
        check("weighted_one_share", (n_one >= 902 && n_one <= 1146), 1);
        check("weighted_ff_share", (n_ff >= 902 && n_ff <= 1146), 1);

        gen_push(2'd1, 5'h15, 100);
        base = xfers1;
        @(posedge clk); #1;
        mode = 2'd1;
        op_sel = 5'h15;
        num_runs = 16'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (xfers1 - base < 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrst_reached", xfers1 - base >= 10, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q1.delete();
        ma = 16'hACE1;
        mb = 16'hACE1 ^ 16'h5A5A;
        check("midrst_state", {v1, busy1, done1}, 3'b000);
        check("midrst_count", cnt1, 0);
        check("midrst_vector", {operation1, a1, b1, c1}, 0);

        push_hand(0, 1, 5'h1F);
        do_run(1'b0, 2'd0, 5'h1F, 16'd1, 1'b0, w);
        check("reseed_count", cnt1, 1);
        repeat (2) @(posedge clk);
        check("final_q1_empty", q1.size(), 0);
        check("final_q2_empty", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_stim_gen.md
# alu_stim_gen

Synthesizable, parametrised stimulus generator for the pipelined PicoBlaze ALU. It produces a programmed number of ALU operand vectors and pushes them through a valid/ready handshake into the ALU driver or the DUT input stage. Three modes are supported: uniform random, corner-weighted random (zero / one / all-ones / random), and exhaustive operand sweep. It sits beside the ALU in the verification harness, and can also run on FPGA for self-test.

## Interface
Parameters:
- OPERAND_WIDTH, 8: width of operand_a and operand_b; must be ≤ LFSR_WIDTH-3.
- OPCODE_WIDTH, 5: width of the op_sel and operation fields.
- LFSR_WIDTH, 16: width of each LFSR; fixed polynomial x^16+x^14+x^13+x^11+1 (Galois mask 16'hB400).
- RUN_WIDTH, 16: width of num_runs and issued_count.
- SEED, 16'hACE1: LFSR A reset value; must be nonzero and ≠ 16'h5A5A.

Ports:
- clk, in, 1: the block's only clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: begin a run; sampled only in IDLE and DONE.
- mode, in, 2: 0 = random, 1 = corner-weighted, 2 = sweep, 3 = same as 0; sampled at start.
- op_sel, in, OPCODE_WIDTH: opcode driven on every vector of the run; sampled at start.
- num_runs, in, RUN_WIDTH: number of vectors to issue; sampled at start.
- op_valid, out, 1: vector present.
- op_ready, in, 1: consumer accepts the vector.
- operation, out, OPCODE_WIDTH: opcode.
- operand_a, out, OPERAND_WIDTH: operand A.
- operand_b, out, OPERAND_WIDTH: operand B.
- carry_in, out, 1: carry input.
- busy, out, 1: high in DRIVE.
- done, out, 1: high in DONE.
- issued_count, out, RUN_WIDTH: number of accepted transfers in the current or last run.

## Operation
- FSM states: IDLE, DRIVE, DONE.
  - IDLE, start=1: if num_runs==0, go to DONE. Otherwise go to DRIVE with the first vector presented.
  - DRIVE: a transfer occurs when op_valid && op_ready.
    - On each transfer, issued_count increments.
    - If the incremented issued_count equals num_runs, go to DONE. Otherwise present the next vector in the following cycle.
  - DONE: holds until start=1, then behaves as IDLE (restart).
- Registers sampled at start: mode, op_sel, num_runs. issued_count clears to 0 at start.
- Vector generation:
  - LFSR A (reset to SEED) and LFSR B (reset to SEED^16'h5A5A) each advance exactly once per generated vector.
  - Generated vectors are the first vector at start, and one new vector after each non-final transfer.
  - LFSRs are not re-seeded at start, so consecutive runs continue the sequence.
- Operand value rule (field shown for A; B uses LFSR B):
  - mode 0: operand = lfsr[OPERAND_WIDTH-1:0].
  - mode 1: the selector is lfsr[LFSR_WIDTH-1:LFSR_WIDTH-2]:
    - 00 → 0
    - 01 → 1
    - 10 → all ones
    - 11 → lfsr[OPERAND_WIDTH-1:0]
- carry_in:
  - modes 0, 1, 3: carry_in = lfsr_a[LFSR_WIDTH-3].
  - mode 2: carry_in = 0.
- Sweep (mode 2):
  - The first vector is a=0, b=0.
  - operand_a increments on each transfer.
  - When operand_a wraps from all ones to 0, operand_b increments; operand_b wraps to 0 after all ones.
  - The LFSRs still advance once per generated vector.
- operation always equals the sampled op_sel.
- Vector outputs hold their last value when op_valid=0.

## Timing
- Reset values:
  - State IDLE.
  - op_valid, busy, done, carry_in = 0.
  - operation, operand_a, operand_b, issued_count = 0.
  - LFSRs = seeds.
- Start latency: start in cycle N gives op_valid=1 (first vector) in cycle N+1. If num_runs==0, done=1 in N+1 and no transfer occurs.
- Handshake:
  - Once op_valid is high, the vector fields stay stable until a transfer occurs.
  - op_valid never drops without a transfer, except on reset.
  - op_ready may be high with op_valid low; this has no effect.
- Throughput: with op_ready held high, one transfer per cycle, so num_runs vectors occupy cycles N+1 … N+num_runs.
- After the final transfer in cycle M: in M+1, op_valid=0, busy=0, done=1.
- start while in DRIVE is ignored.
- issued_count updates in the cycle after each transfer.
- Reset asserted mid-run: in the next cycle all outputs are at reset values and there is no partial vector. A transfer in the reset cycle is not counted.

## Test plan
- Reset: assert reset for 2 cycles → op_valid=0, done=0, busy=0, issued_count=0. Then mode 0 with num_runs=1 gives operand_a = 8'hE1, matching the low byte of SEED as the first LFSR value.
- Zero runs: start, num_runs=0 → done=1 the next cycle; op_valid never asserts; issued_count=0.
- Back-to-back: mode 0, num_runs=4, op_ready=1 → exactly 4 consecutive valid cycles, done=1 on the 5th cycle after start, issued_count=4. Vectors match a reference LFSR model.
- Backpressure: same as above, but op_ready toggles 1,0,0,1,… → vectors are stable while stalled; 4 transfers total; no vector is skipped or duplicated.
- Sweep wrap: OPERAND_WIDTH=2, mode 2, num_runs=6, op_sel=5'h0A → (a,b) sequence (0,0),(1,0),(2,0),(3,0),(0,1),(1,1); carry_in=0 and operation=0A throughout.
- Weighted mode plus mid-run reset: mode 1, num_runs=4096 → operand_a==0, ==1 and ==8'hFF each occur within 25%±3% of vectors. Then restart, and assert reset after 10 transfers → op_valid=0 the next cycle and state is IDLE.
